// File: rtl/audio_sample_scheduler_if.sv
// rtl/audio_sample_scheduler_if.sv - codec/requester bundle for the audio sample scheduler
interface audio_sample_scheduler_if #(
  parameter int FRAME_W = 16
);
  logic               START;
  logic               INIT;
  logic               INIT_FINISH;
  logic               DATA_OVER;
  logic [15:0]        LDATA;
  logic [15:0]        RDATA;
  logic               MUS_VALID;
  logic [15:0]        MUS_SAMPLE;
  logic               MUS_READY;
  logic               FX_VALID;
  logic [15:0]        FX_SAMPLE;
  logic               FX_READY;
  logic [FRAME_W-1:0] FRAME_CNT;
  logic               MUS_DONE;
  logic               UNDERRUN;
  logic               INIT_ERR;

  modport master (
    input  START, INIT_FINISH, DATA_OVER, MUS_VALID, MUS_SAMPLE, FX_VALID, FX_SAMPLE,
    output INIT, LDATA, RDATA, MUS_READY, FX_READY, FRAME_CNT, MUS_DONE, UNDERRUN, INIT_ERR
  );

  modport slave (
    output START, INIT_FINISH, DATA_OVER, MUS_VALID, MUS_SAMPLE, FX_VALID, FX_SAMPLE,
    input  INIT, LDATA, RDATA, MUS_READY, FX_READY, FRAME_CNT, MUS_DONE, UNDERRUN, INIT_ERR
  );
endinterface

// File: rtl/audio_sample_scheduler.sv
// rtl/audio_sample_scheduler.sv - codec init sequencing and saturating music+effect mix per DATA_OVER
module audio_sample_scheduler #(
  parameter int NUM_FRAMES   = 48000,
  parameter int INIT_TIMEOUT = 1000000,
  parameter int FX_SHIFT     = 1,
  parameter int FRAME_W      = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  audio_sample_scheduler_if.master  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_FETCH, S_MIX, S_PLAY, S_DONE, S_ERR
  } state_t;

  localparam int TW = $clog2(INIT_TIMEOUT) + 1;

  state_t              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic signed [15:0]  mus_q, mus_d;
  logic signed [15:0]  fx_q, fx_d;
  logic [15:0]         pend_q, pend_d;
  logic [15:0]         ldata_q, ldata_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                underrun_q, underrun_d;

  logic signed [15:0]  fx_att;
  logic [16:0]         mix_sum;
  logic [15:0]         mix_sat;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      mus_q      <= '0;
      fx_q       <= '0;
      pend_q     <= '0;
      ldata_q    <= '0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      mus_q      <= mus_d;
      fx_q       <= fx_d;
      pend_q     <= pend_d;
      ldata_q    <= ldata_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  // 17-bit sum cannot wrap; disagreement of the top two bits means out of 16-bit range
  always_comb begin
    fx_att  = fx_q >>> FX_SHIFT;
    mix_sum = {mus_q[15], mus_q} + {fx_att[15], fx_att};
    mix_sat = mix_sum[15:0];
    if (mix_sum[16] != mix_sum[15]) begin
      mix_sat = mix_sum[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    mus_d      = mus_q;
    fx_d       = fx_q;
    pend_d     = pend_q;
    ldata_d    = ldata_q;
    frame_d    = frame_q;
    underrun_d = underrun_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_INIT_REQ;
      end
      S_INIT_REQ: begin
        tcnt_d  = '0;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (bus.INIT_FINISH)                      state_d = S_FETCH;
        else if (tcnt_q == TW'(INIT_TIMEOUT - 1)) state_d = S_ERR;
        else                                      tcnt_d  = tcnt_q + TW'(1);
      end
      S_FETCH: begin
        if (bus.DATA_OVER) underrun_d = 1'b1;
        if (bus.MUS_VALID) begin
          mus_d   = bus.MUS_SAMPLE;
          fx_d    = bus.FX_VALID ? bus.FX_SAMPLE : 16'h0000;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        if (bus.DATA_OVER) underrun_d = 1'b1;
        pend_d  = mix_sat;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.DATA_OVER) begin
          ldata_d = pend_q;
          frame_d = frame_q + FRAME_W'(1);
          state_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (bus.START) begin
          frame_d    = '0;
          underrun_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.INIT      = (state_q == S_INIT_REQ);
    bus.MUS_READY = (state_q == S_FETCH);
    bus.FX_READY  = (state_q == S_FETCH) && bus.MUS_VALID;
    bus.MUS_DONE  = (state_q == S_DONE);
    bus.INIT_ERR  = (state_q == S_ERR);
    bus.LDATA     = ldata_q;
    bus.RDATA     = ldata_q;
    bus.FRAME_CNT = frame_q;
    bus.UNDERRUN  = underrun_q;
  end
endmodule
